swap_seq: RTL

SWAP_SEQ -- requirements
Module: swap_seq

---
 rtl/swap_seq.sv | 114 +++++++++++
 1 files changed

// File: rtl/swap_seq.sv
// Register-swap sequencer: reads two registers in one cycle, then writes each
// with the other's value over two cycles. R0 is never written.
module swap_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              start,
  input  logic [3:0]        rs,
  input  logic [3:0]        rt,
  input  logic [DATA_W-1:0] rd_data_a,
  input  logic [DATA_W-1:0] rd_data_b,
  output logic [3:0]        rd_addr_a,
  output logic [3:0]        rd_addr_b,
  output logic [1:0]        mux_sel,
  output logic [3:0]        swap_sel,
  output logic [DATA_W-1:0] wr_data,
  output logic              rf_we,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  // Handshake: start is a request sampled only while busy is low; a request
  // seen at a rising edge with busy low is accepted and busy rises in the
  // following cycle. There is no ready/queue -- requests while busy are dropped.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_WRITE1  = 3'd2,
    S_WRITE2  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state;
  logic [3:0]        ra;
  logic [3:0]        rb;
  logic [DATA_W-1:0] tmp_a;
  logic [DATA_W-1:0] tmp_b;

  assign rd_addr_a = ra;
  assign rd_addr_b = rb;
  assign dbg_state = state;

  // Outputs are registered for the state being entered, so they change in
  // lockstep with the state register.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state    <= S_IDLE;
      ra       <= '0;
      rb       <= '0;
      tmp_a    <= '0;
      tmp_b    <= '0;
      mux_sel  <= 2'd0;
      swap_sel <= 4'd0;
      wr_data  <= '0;
      rf_we    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      mux_sel  <= 2'd0;
      swap_sel <= 4'd0;
      wr_data  <= '0;
      rf_we    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ra    <= rs;
            rb    <= rt;
            state <= S_CAPTURE;
            busy  <= 1'b1;
          end
        end
        S_CAPTURE: begin
          tmp_a <= rd_data_a;
          tmp_b <= rd_data_b;
          busy  <= 1'b1;
          if (ra == rb) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state    <= S_WRITE1;
            mux_sel  <= 2'd2;
            swap_sel <= ra;
            wr_data  <= rd_data_b;
            rf_we    <= (ra != 4'd0);
          end
        end
        S_WRITE1: begin
          state    <= S_WRITE2;
          busy     <= 1'b1;
          mux_sel  <= 2'd2;
          swap_sel <= rb;
          wr_data  <= tmp_a;
          rf_we    <= (rb != 4'd0);
        end
        S_WRITE2: begin
          state <= S_DONE;
          busy  <= 1'b1;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
